ram_burst_master: RTL and testbench

RAM_BURST_MASTER -- requirements
Module: ram_burst_master

---
 rtl/ram_burst_master_pkg.sv | 26 ++
 rtl/ram_rd_fifo.sv | 52 +++++
 rtl/ram_burst_master.sv | 111 +++++++++++
 tb/tb_ram_burst_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_master_pkg.sv
// Shared types and default widths for the RAM burst master and its read FIFO.
package ram_burst_master_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned RD_FIFO_DEPTH  = 2;
  localparam int unsigned RD_CNT_WIDTH   = 2;
  localparam int unsigned OCC_WIDTH      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // A read may be issued only if its data is guaranteed a FIFO slot when it returns.
  function automatic logic rd_can_issue(input logic [RD_CNT_WIDTH-1:0] occ,
                                        input logic                    inflight,
                                        input logic                    pop);
    logic [OCC_WIDTH-1:0] total;
    total = OCC_WIDTH'(occ) + OCC_WIDTH'(inflight) - OCC_WIDTH'(pop);
    return total < OCC_WIDTH'(RD_FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry output FIFO buffering registered RAM read data toward the rd_* port.
module ram_rd_fifo
  import ram_burst_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [RD_CNT_WIDTH-1:0] count_o
);

  logic [DATA_WIDTH-1:0]   mem_q [RD_FIFO_DEPTH];
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [RD_CNT_WIDTH-1:0] count_q;
  logic                    pop_ok;
  logic                    push_ok;

  assign pop_ok  = pop_i && (count_q != RD_CNT_WIDTH'(0));
  assign push_ok = push_i && ((count_q != RD_CNT_WIDTH'(RD_FIFO_DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= !wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= !rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + RD_CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - RD_CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Data storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != RD_CNT_WIDTH'(0));
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst master turning write/read burst commands into single-port RAM accesses.
module ram_burst_master
  import ram_burst_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic                    inflight_q;
  logic                    wr_fire;
  logic                    rd_pop;
  logic                    rd_issue;
  logic                    fifo_valid;
  logic [RD_CNT_WIDTH-1:0] fifo_count;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  // Write side is gated by rst_n so an aborting reset can never land a beat in the RAM.
  assign wr_ready  = rst_n && (state_q == ST_WRITE);
  assign wr_fire   = wr_ready && wr_valid;
  assign ram_we    = wr_fire;
  assign ram_addr  = addr_q;
  assign ram_wdata = wr_data;

  assign rd_valid  = fifo_valid;
  assign rd_pop    = fifo_valid && rd_ready;
  assign rd_issue  = rst_n && (state_q == ST_READ) &&
                     rd_can_issue(fifo_count, inflight_q, rd_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            state_q <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_fire) begin
            if (len_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
              len_q  <= len_q - ADDR_WIDTH'(1);
            end
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            if (len_q == '0) begin
              state_q <= ST_DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
              len_q  <= len_q - ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((fifo_count == '0) && !inflight_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data issued last cycle arrives on ram_rdata now and is captured into the FIFO.
  ram_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (ram_rdata),
    .pop_i       (rd_pop),
    .valid_o     (fifo_valid),
    .data_o      (rd_data),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master with a behavioural RAM and expected-memory model.
module tb_ram_burst_master;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int tests;
  int fails;

  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read, read every cycle.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 = wr_valid always, 1 = random, 2 = per-cycle mask. Garbage commands are offered while busy.
  task automatic do_write(input int addr, input int len, input int mode, input logic [15:0] mask,
                          input logic [7:0] base, input bit rnd);
    int beat;
    int c;
    logic [DW-1:0] d;
    beat = 0;
    c = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(addr); cmd_len = AW'(len); wr_valid = 1'b0;
    #1 check("wr_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    while (beat <= len && c < 200) begin
      d = rnd ? DW'($urandom) : DW'(base + 8'(beat));
      wr_data = d;
      case (mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = ($urandom % 4) != 0;
        default: wr_valid = (c < 16) ? mask[c] : 1'b1;
      endcase
      cmd_valid = !(wr_valid && beat == len);
      cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_len = AW'($urandom);
      #1;
      check("wr_ready", wr_ready, 1);
      check("wr_busy", busy, 1);
      check("wr_ram_we", ram_we, wr_valid);
      if (wr_valid) begin
        check("wr_ram_addr", ram_addr, (addr + beat) % DEPTH);
        check("wr_ram_wdata", ram_wdata, d);
        ref_mem[(addr + beat) % DEPTH] = d;
        beat++;
      end
      c++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    cmd_valid = 1'b0;
    check("wr_beats", beat, len + 1);
    #1;
    check("wr_done_idle", busy, 0);
    check("wr_done_cmd_ready", cmd_ready, 1);
  endtask

  // mode: 0 = rd_ready always, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic do_read(input int addr, input int len, input int mode);
    int k;
    int c;
    int t;
    k = 0;
    c = 0;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(addr); cmd_len = AW'(len); rd_ready = 1'b0;
    #1 check("rd_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (k <= len && c < 400) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (c % 3) == 0;
        default: rd_ready = 1'($urandom);
      endcase
      #1;
      check("rd_fifo_occ_le2", 32'(dut.u_fifo.count_o <= 2), 1);
      check("rd_ram_we_low", ram_we, 0);
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, ref_mem[(addr + k) % DEPTH]);
        if (mode == 0) check("rd_beat_cycle", c, 2 + k);
        k++;
      end
      c++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check("rd_beats", k, len + 1);
    #1;
    while (busy && t < 8) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("rd_done_idle", busy, 0);
    check("rd_done_no_valid", rd_valid, 0);
    if (mode == 0) check("rd_drain_cycles", t, 1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    rst_n = 1'b1;

    // 4-beat write at 3, read back with rd_ready high.
    do_write(3, 3, 0, 16'h0, 8'hA0, 1'b0);
    do_read(3, 3, 0);

    // Wrapping burst across the top of the address space.
    do_write(14, 3, 0, 16'h0, 8'h11, 1'b0);
    do_read(14, 3, 0);

    // Fill the whole RAM, then full-depth read from 0.
    do_write(0, DEPTH - 1, 1, 16'h0, 8'h00, 1'b1);
    do_read(0, DEPTH - 1, 0);

    // 8 beats with rd_ready toggling 1,0,0.
    do_read(5, 7, 1);

    // Write with wr_valid only on cycles 0, 2, 5.
    do_write(9, 2, 2, 16'h0025, 8'h5A, 1'b0);
    do_read(9, 2, 2);

    for (int i = 0; i < 10; i++) begin
      if ($urandom % 2 == 1) do_write(int'($urandom % DEPTH), int'($urandom % DEPTH), 1, 16'h0, 8'h00, 1'b1);
      else                   do_read(int'($urandom % DEPTH), int'($urandom % DEPTH), 2);
    end

    // Reset mid-read with two beats buffered.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(5); cmd_len = AW'(7); rd_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("mid_rd_valid", rd_valid, 1);
    check("mid_rd_buffered", 32'(dut.u_fifo.count_o), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rrst_rd_valid", rd_valid, 0);
    check("rrst_busy", busy, 0);
    check("rrst_cmd_ready", cmd_ready, 1);
    check("rrst_ram_addr", ram_addr, 0);
    do_read(11, 6, 2);

    // Reset mid-write: only the handshaked beat lands in the RAM.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(8); cmd_len = AW'(3);
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hEE;
    #1;
    check("wrst_first_we", ram_we, 1);
    ref_mem[8] = 8'hEE;
    @(negedge clk);
    wr_data = 8'hEF; rst_n = 1'b0;
    #1;
    check("wrst_we_in_reset", ram_we, 0);
    check("wrst_wr_ready_in_reset", wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    #1;
    check("wrst_busy", busy, 0);
    check("wrst_wr_ready", wr_ready, 0);
    do_read(0, DEPTH - 1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
